// File: rtl/pq_request_frontend.sv
// pq_request_frontend
//   Command front end for a register-array max priority queue. It accepts
//   push and pop requests on valid/ready handshakes and merges a coincident
//   push and pop into one replace. It drives the queue strobes and tracks
//   occupancy in a shadow counter so the queue never overflows or underflows.
//   It waits ISSUE_GAP idle cycles after each operation so the queue can
//   settle, and returns popped maxima through a one-entry registered slot.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   s_push_*          push request channel (valid/ready/data)
//   s_pop_*           pop request channel (valid/ready)
//   m_pop_*           popped-value result channel (valid/ready/data)
//   q_wrt/q_read      strobes to the queue's i_wrt / i_read
//   q_data            value to the queue's i_data
//   q_max             current maximum from the queue's o_data
//   o_count           shadow occupancy
//   o_busy            high while an operation is being issued or settling
module pq_request_frontend #(
  parameter int QUEUE_SIZE = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ISSUE_GAP  = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          s_push_valid,
  output logic                          s_push_ready,
  input  logic [DATA_WIDTH-1:0]         s_push_data,
  input  logic                          s_pop_valid,
  output logic                          s_pop_ready,
  output logic                          m_pop_valid,
  input  logic                          m_pop_ready,
  output logic [DATA_WIDTH-1:0]         m_pop_data,
  output logic                          q_wrt,
  output logic                          q_read,
  output logic [DATA_WIDTH-1:0]         q_data,
  input  logic [DATA_WIDTH-1:0]         q_max,
  output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
  output logic                          o_busy
);

  localparam int CW = $clog2(QUEUE_SIZE + 1);
  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP + 1) : 1;
  localparam logic [CW-1:0] FULL = CW'(QUEUE_SIZE);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

  state_t          state;
  state_t          state_next;
  logic            op_push;
  logic            op_pop;
  logic [GW-1:0]   gap_cnt;
  logic            slot_free;
  logic            idle;
  logic            push_fire;
  logic            pop_fire;

  // Handshake decode and FSM next-state / strobe outputs.
  always_comb begin
    slot_free  = !m_pop_valid || m_pop_ready;
    // Readies are masked while reset is asserted so nothing is accepted then.
    idle       = (state == IDLE) && !RST;
    s_pop_ready  = idle && (o_count != '0) && slot_free;
    // A full queue can still take a push if it is paired with a pop (replace).
    s_push_ready = idle && ((o_count < FULL) || (s_pop_valid && slot_free));
    push_fire  = s_push_valid && s_push_ready;
    pop_fire   = s_pop_valid && s_pop_ready;

    state_next = state;
    q_wrt      = 1'b0;
    q_read     = 1'b0;
    o_busy     = (state != IDLE);

    case (state)
      IDLE: begin
        if (push_fire || pop_fire) state_next = ISSUE;
      end
      ISSUE: begin
        q_wrt      = op_push;
        q_read     = op_pop;
        state_next = (ISSUE_GAP > 0) ? SETTLE : IDLE;
      end
      SETTLE: begin
        if (gap_cnt <= GW'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Operation latch, occupancy, settle counter and result slot.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_push     <= 1'b0;
      op_pop      <= 1'b0;
      q_data      <= '0;
      o_count     <= '0;
      gap_cnt     <= '0;
      m_pop_valid <= 1'b0;
      m_pop_data  <= '0;
    end else begin
      if (state == IDLE && (push_fire || pop_fire)) begin
        op_push <= push_fire;
        op_pop  <= pop_fire;
        if (push_fire) q_data <= s_push_data;
      end

      if (state == ISSUE) begin
        gap_cnt <= GW'(ISSUE_GAP);
        if (op_push && !op_pop)      o_count <= o_count + 1'b1;
        else if (!op_push && op_pop) o_count <= o_count - 1'b1;
      end else if (state == SETTLE) begin
        gap_cnt <= gap_cnt - 1'b1;
      end

      // A capture wins over the consumer draining the slot on the same edge;
      // pops are only accepted with the slot free, so nothing is lost.
      if (state == ISSUE && op_pop) begin
        m_pop_data  <= q_max;
        m_pop_valid <= 1'b1;
      end else if (m_pop_ready) begin
        m_pop_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pq_request_frontend.md
Name: pq_request_frontend

Overview:
- Upstream command stage for the register-array max priority queue.
- Accepts independent push and pop requests over valid/ready handshakes and merges coincident requests into a single replace.
- Drives the queue's write/read/data strobes, guards full and empty with a shadow occupancy counter, and enforces a settle gap between operations.
- Returns popped maxima on a registered valid/ready result channel.

Parameters:
- QUEUE_SIZE, 4, capacity of the attached queue; even, >=2.
- DATA_WIDTH, 16, entry width.
- ISSUE_GAP, 1, idle cycles inserted after every issued operation; 0 allows back-to-back issue.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- s_push_valid  in  1  push request.
- s_push_ready  out  1  push accepted this cycle when both valid and ready are high.
- s_push_data  in  DATA_WIDTH  value to insert.
- s_pop_valid  in  1  pop request.
- s_pop_ready  out  1  pop accepted this cycle when both valid and ready are high.
- m_pop_valid  out  1  popped value available.
- m_pop_ready  in  1  consumer takes the popped value.
- m_pop_data  out  DATA_WIDTH  popped value.
- q_wrt  out  1  to queue i_wrt.
- q_read  out  1  to queue i_read.
- q_data  out  DATA_WIDTH  to queue i_data.
- q_max  in  DATA_WIDTH  from queue o_data (current maximum).
- o_count  out  $clog2(QUEUE_SIZE+1)  shadow occupancy.
- o_busy  out  1  high in ISSUE or SETTLE.

Behaviour:
- Reset: all outputs and internal state cleared to 0; FSM enters IDLE. Reset is honoured in any state; a request in flight is dropped and not replayed.
- Occupancy: the block is the queue's only master. o_count tracks occupancy: +1 on enqueue, -1 on dequeue, unchanged on replace. It never exceeds QUEUE_SIZE and never goes below 0.
- Output slot: a single-entry register holding the popped value.
  - slot_free = !m_pop_valid || m_pop_ready.
- Ready rules, combinational, asserted only in IDLE:
  - s_push_ready = IDLE && (o_count<QUEUE_SIZE || (s_pop_valid && slot_free)).
  - s_pop_ready = IDLE && o_count>0 && slot_free.
  - Pop ready never depends on push valid.
- Operation selection, on the accepted handshakes in IDLE:
  - Push and pop both accepted: replace.
  - Push only: enqueue. This includes the empty case, where push is accepted and pop is held with pop_ready=0.
  - Pop only: dequeue.
  - Nothing accepted: stay in IDLE.
- IDLE -> ISSUE: on acceptance, latch the operation type and s_push_data.
- ISSUE (exactly 1 cycle):
  - Drive the strobes: enqueue q_wrt=1, q_read=0; dequeue q_wrt=0, q_read=1; replace both high. q_data is the latched value.
  - For dequeue or replace, capture q_max into the slot and set m_pop_valid=1 at the next edge.
  - Update o_count at the same edge.
  - Next state is SETTLE if ISSUE_GAP>0, else IDLE.
- SETTLE: count down ISSUE_GAP cycles with all q_* strobes low, then return to IDLE. Worst-case request-to-request spacing is 2+ISSUE_GAP cycles.
- Result channel: m_pop_valid drops on m_pop_ready unless a new capture occurs on the same edge. Because pop is accepted only when slot_free, no popped value is ever overwritten or lost. m_pop_data is held stable while m_pop_valid && !m_pop_ready.
- Outside ISSUE: q_wrt and q_read are low; q_data holds its last value.
- Latency: accept to strobe is 1 cycle; strobe to m_pop_valid is 1 cycle.

Test Plan:
- Reset then push 5, 9, 3 with ISSUE_GAP=1 -> three single-cycle q_wrt pulses spaced 3 cycles apart; o_count=3; m_pop_valid stays 0.
- With queue {9,5,3}, pop with m_pop_ready=1 -> one q_read pulse; m_pop_data=9 with m_pop_valid high one cycle after the strobe; o_count=2.
- Fill to 4 entries, then assert push alone -> s_push_ready=0 indefinitely, no strobes. Then push 7 and pop together -> q_wrt and q_read high together; old max returned; o_count stays 4.
- Empty queue, push 4 and pop together -> enqueue only, pop held (s_pop_ready=0). Next IDLE pop accepted -> m_pop_data=4; o_count=0.
- Two pops with m_pop_ready=0 -> first value held stable; second pop blocked (s_pop_ready=0) until m_pop_ready rises; both values delivered in descending order.
- Assert RST during SETTLE after a push -> all outputs 0 immediately; IDLE on release; o_count=0.
